// File: rtl/counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl_if
// Brief   : Command valid/ready handshake between a command source and
//           counter_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface counter_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl
// Brief   : Prescaled up/down counter sequencer with start/stop/load/clear
//           commands, programmable limit and one-shot or wrap termination.
// Revision: 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    counter_ctrl_if.slave         cmd,
    input  wire logic [WIDTH-1:0] limit,
    input  wire logic [DIV_W-1:0] div,
    input  wire logic             mode,
    input  wire logic             up_dn,
    output logic      [WIDTH-1:0] count,
    output logic                  tick,
    output logic                  running,
    output logic                  done
);

    localparam logic [1:0] c_OP_START = 2'b00;
    localparam logic [1:0] c_OP_STOP  = 2'b01;
    localparam logic [1:0] c_OP_LOAD  = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [DIV_W-1:0] r_pre;
    logic             r_tick;
    logic             r_done;
    logic             r_ready;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [DIV_W-1:0] w_pre_nxt;
    logic             w_tick_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;
    logic             w_accept;
    logic             w_pre_hit;
    logic             w_step;
    logic             w_terminal;

    assign w_accept   = cmd.cmd_valid && r_ready;
    assign w_pre_hit  = (r_pre == div);
    assign w_step     = (r_state == ST_RUN) && w_pre_hit;
    assign w_terminal = up_dn ? (r_count == limit) : (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pre   <= w_pre_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        // ready is withheld for the single cycle following any acceptance
        w_ready_nxt = !w_accept;
        w_pre_nxt   = '0;
        if ((r_state == ST_RUN) && !w_pre_hit) begin
            w_pre_nxt = r_pre + DIV_W'(1);
        end

        // an accepted command pre-empts a coincident step entirely
        if (w_accept) begin
            case (cmd.cmd_op)
                c_OP_START: begin
                    if (r_state != ST_RUN) begin
                        w_state_nxt = ST_RUN;
                        w_pre_nxt   = '0;
                    end
                end
                c_OP_STOP: begin
                    if (r_state == ST_RUN) begin
                        w_state_nxt = ST_IDLE;
                        w_pre_nxt   = '0;
                    end
                end
                c_OP_LOAD: begin
                    w_count_nxt = cmd.cmd_data;
                    w_pre_nxt   = '0;
                end
                c_OP_CLEAR: begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                    w_pre_nxt   = '0;
                end
                default: ;
            endcase
        end else if (w_step) begin
            w_tick_nxt = 1'b1;
            if (w_terminal) begin
                w_done_nxt = 1'b1;
                if (mode) begin
                    w_count_nxt = up_dn ? '0 : limit;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end else begin
                w_count_nxt = up_dn ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
            end
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign count         = r_count;
    assign tick          = r_tick;
    assign done          = r_done;
    assign running       = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_ctrl
// Brief   : Directed scoreboard bench for counter_ctrl; expected steps are
//           queued by the stimulus and consumed by a tick monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;
    localparam int WIDTH = 4;
    localparam int DIV_W = 8;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] limit;
    logic [DIV_W-1:0] div;
    logic             mode;
    logic             up_dn;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             running;
    logic             done;

    counter_ctrl_if #(.WIDTH(WIDTH)) cif ();

    counter_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cif),
        .limit   (limit),
        .div     (div),
        .mode    (mode),
        .up_dn   (up_dn),
        .count   (count),
        .tick    (tick),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             dn;
        int               gap;   // cycles since previous tick, 0 = unchecked
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_pass    = 0;
    int   n_total   = 0;
    int   cyc       = 0;
    int   last_tick = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int c, input int d, input int g);
        exp_t e;
        e.cnt = WIDTH'(c);
        e.dn  = d[0];
        e.gap = g;
        q.push_back(e);
    endtask

    // Monitor: every tick must match the head of the expectation queue
    always @(negedge clk) begin
        cyc++;
        if (!rst && tick) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_tick: count=%0d done=%0d, expected no step (t=%0t)",
                         count, done, $time);
            end else begin
                mon_e = q.pop_front();
                chk("tick_count", int'(count), int'(mon_e.cnt));
                chk("tick_done", int'(done), int'(mon_e.dn));
                if (mon_e.gap != 0) chk("tick_gap", cyc - last_tick, mon_e.gap);
            end
            last_tick = cyc;
        end else if (!rst && done) begin
            chk("done_without_tick", int'(done), 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        for (int i = 0; i < 20; i++) begin
            if (cif.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 0, 1);
        end
        cif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_START;
        cif.cmd_data  = '0;
        limit = 4'd15; div = 8'd200; mode = 1'b1; up_dn = 1'b1;

        // Power-on reset state
        repeat (2) @(negedge clk);
        chk("por_count", int'(count), 0);
        chk("por_running", int'(running), 0);
        chk("por_ready", int'(cif.cmd_ready), 1);
        chk("por_tick", int'(tick), 0);
        chk("por_done", int'(done), 0);
        rst = 1'b0;

        // Reset mid-run with count=5
        send(OP_LOAD, 4'd5);
        send(OP_START, 4'd0);
        repeat (3) @(negedge clk);
        chk("t1_running_before", int'(running), 1);
        chk("t1_count_before", int'(count), 5);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_count", int'(count), 0);
        chk("t1_running", int'(running), 0);
        chk("t1_ready", int'(cif.cmd_ready), 1);
        chk("t1_tick", int'(tick), 0);
        chk("t1_done", int'(done), 0);
        rst = 1'b0;

        // Wrap-mode up count, div=2, limit=3
        div = 8'd2; limit = 4'd3; up_dn = 1'b1; mode = 1'b1;
        push(1, 0, 0); push(2, 0, 3); push(3, 0, 3); push(0, 1, 3); push(1, 0, 3);
        send(OP_START, 4'd0);
        drain();
        send(OP_STOP, 4'd0);
        @(negedge clk);
        chk("t2_running_after_stop", int'(running), 0);
        repeat (6) @(negedge clk);
        chk("t2_count_frozen", int'(count), 1);

        // One-shot down count from 2, div=0
        div = 8'd0; up_dn = 1'b0; mode = 1'b0;
        send(OP_LOAD, 4'd2);
        push(1, 0, 0); push(0, 0, 1); push(0, 1, 1);
        send(OP_START, 4'd0);
        drain();
        chk("t3_running_done", int'(running), 0);
        chk("t3_count_done", int'(count), 0);
        repeat (5) @(negedge clk);
        chk("t3_count_held", int'(count), 0);

        // Handshake: STOP held while ready is low after START
        div = 8'd50; up_dn = 1'b1; mode = 1'b1; limit = 4'd3;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_START;
        chk("t4_ready_before", int'(cif.cmd_ready), 1);
        @(negedge clk);
        cif.cmd_op = OP_STOP;
        chk("t4_ready_drop", int'(cif.cmd_ready), 0);
        chk("t4_running_start", int'(running), 1);
        @(negedge clk);
        chk("t4_ready_back", int'(cif.cmd_ready), 1);
        chk("t4_stop_not_yet", int'(running), 1);
        @(posedge clk);
        #1 cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_running_stopped", int'(running), 0);
        repeat (3) @(negedge clk);
        chk("t4_count_frozen", int'(count), 0);

        // LOAD on a step cycle, then wrap through all-ones to limit=3
        div = 8'd0; up_dn = 1'b1; mode = 1'b1; limit = 4'd3;
        send(OP_LOAD, 4'd6);
        push(7, 0, 0);
        push(13, 0, 2); push(14, 0, 1); push(15, 0, 1); push(0, 0, 1);
        push(1, 0, 1);  push(2, 0, 1);  push(3, 0, 1);  push(0, 1, 1);
        send(OP_START, 4'd0);
        send(OP_LOAD, 4'd12);
        @(negedge clk);
        chk("t5_load_count", int'(count), 12);
        chk("t5_load_no_tick", int'(tick), 0);
        repeat (8) @(posedge clk);
        send(OP_STOP, 4'd0);
        @(negedge clk);
        chk("t5_count_after_stop", int'(count), 0);
        chk("t5_running_after_stop", int'(running), 0);
        chk("t5_queue_empty", q.size(), 0);

        // CLEAR from DONE with count=9, restart from 0
        div = 8'd0; up_dn = 1'b1; mode = 1'b0; limit = 4'd9;
        send(OP_LOAD, 4'd7);
        push(8, 0, 0); push(9, 0, 1); push(9, 1, 1);
        send(OP_START, 4'd0);
        drain();
        chk("t6_running_done", int'(running), 0);
        chk("t6_count_done", int'(count), 9);
        send(OP_CLEAR, 4'd0);
        @(negedge clk);
        chk("t6_count_clear", int'(count), 0);
        chk("t6_running_clear", int'(running), 0);
        div = 8'd1; mode = 1'b1;
        push(1, 0, 0); push(2, 0, 2);
        send(OP_START, 4'd0);
        drain();
        send(OP_STOP, 4'd0);
        @(negedge clk);
        chk("t6_count_final", int'(count), 2);
        chk("t6_running_final", int'(running), 0);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
